// File: rtl/sqrt_reconstruct_if.sv
// sqrt_reconstruct_if: operand request and result bus between a requester and sqrt_reconstruct.
// Revision 1.0
`default_nettype none

interface sqrt_reconstruct_if #(
  parameter int WIDTH = 16
);
  logic                 start_i;
  logic [WIDTH-1:0]     root_i;
  logic [WIDTH:0]       rem_i;
  logic                 busy_o;
  logic                 done_o;
  logic [2*WIDTH-1:0]   radicand_o;
  logic                 valid_o;
  logic                 ovf_o;

  modport master (
    output start_i, root_i, rem_i,
    input  busy_o, done_o, radicand_o, valid_o, ovf_o
  );

  modport slave (
    input  start_i, root_i, rem_i,
    output busy_o, done_o, radicand_o, valid_o, ovf_o
  );
endinterface

`default_nettype wire

// File: rtl/sqrt_reconstruct.sv
// sqrt_reconstruct: rebuilds radicand = root*root + rem with a shift-add multiplier, flags rem <= 2*root.
// Revision 1.0
`default_nettype none

module sqrt_reconstruct #(
  parameter int WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sqrt_reconstruct_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int              CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

  state_t               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [WIDTH:0]       rem_q;
  logic                 flag_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 valid_q;
  logic                 ovf_q;
  logic [2*WIDTH-1:0]   rad_q;

  logic [WIDTH:0]       part_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH:0]     sum_d;
  logic                 accept_d;

  always_comb begin
    // The partial product lands in the top WIDTH+1 bits, then the whole accumulator shifts right.
    part_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_d    = {part_d, acc_q[WIDTH-1:1]};
    sum_d    = {1'b0, acc_q} + {{WIDTH{1'b0}}, rem_q};
    accept_d = bus.start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      flag_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      rad_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept_d) begin
            mcand_q  <= bus.root_i;
            mplier_q <= bus.root_i;
            rem_q    <= bus.rem_i;
            flag_q   <= (bus.rem_i <= {bus.root_i, 1'b0});
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_MUL;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == C_LAST) begin
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          rad_q   <= sum_d[2*WIDTH-1:0];
          ovf_q   <= sum_d[2*WIDTH];
          valid_q <= flag_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.radicand_o = rad_q;
  assign bus.valid_o    = valid_q;
  assign bus.ovf_o      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_reconstruct.sv
// tb_sqrt_reconstruct: directed vectors with a result queue checked by an independent monitor.
// Revision 1.0
`default_nettype none

module tb_sqrt_reconstruct;

  localparam int WIDTH = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  sqrt_reconstruct_if #(.WIDTH(WIDTH)) bus ();

  sqrt_reconstruct #(.WIDTH(WIDTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] rad;
    logic        v;
    logic        o;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (bus.done_o) begin
      if (q.size() == 0) begin
        fail_now("spurious_done");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("radicand", {32'd0, bus.radicand_o}, {32'd0, e.rad});
        check("valid",    {63'd0, bus.valid_o},    {63'd0, e.v});
        check("ovf",      {63'd0, bus.ovf_o},      {63'd0, e.o});
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [15:0] r, input logic [16:0] m, input bit push,
                       input logic [31:0] erad, input logic ev, input logic eo);
    int n;
    n = 0;
    while (bus.busy_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (bus.busy_o) fail_now("issue_wait");
    bus.root_i  = r;
    bus.rem_i   = m;
    bus.start_i = 1'b1;
    if (push) q.push_back('{rad: erad, v: ev, o: eo});
    @(negedge clk_i);
    bus.start_i = 1'b0;
    bus.root_i  = 16'($urandom);
    bus.rem_i   = 17'($urandom);
  endtask

  task automatic issue_model(input logic [15:0] r, input logic [16:0] m);
    logic [32:0] s;
    s = {17'd0, r} * {17'd0, r} + {16'd0, m};
    issue(r, m, 1'b1, s[31:0], (m <= {r, 1'b0}), s[32]);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.done_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!bus.done_o) fail_now(name);
  endtask

  initial begin
    int          j;
    int          bcnt;
    int          seen;
    logic [15:0] roots [12];

    bus.start_i = 1'b0;
    bus.root_i  = '0;
    bus.rem_i   = '0;
    repeat (3) @(negedge clk_i);
    check("rst_busy",     {63'd0, bus.busy_o},     64'd0);
    check("rst_done",     {63'd0, bus.done_o},     64'd0);
    check("rst_radicand", {32'd0, bus.radicand_o}, 64'd0);
    check("rst_valid",    {63'd0, bus.valid_o},    64'd0);
    check("rst_ovf",      {63'd0, bus.ovf_o},      64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Latency and busy window on the zero operand.
    issue(16'h0000, 17'h00000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    bcnt = bus.busy_o ? 1 : 0;
    j = 0;
    while (!bus.done_o && j < 40) begin
      @(negedge clk_i);
      j++;
      if (bus.busy_o) bcnt++;
    end
    check("latency",     64'(j),    64'd17);
    check("busy_cycles", 64'(bcnt), 64'd17);
    check("busy_in_done", {63'd0, bus.busy_o}, 64'd0);

    issue(16'h1234, 17'h00000, 1'b1, 32'h014B_5A90, 1'b1, 1'b0);
    issue(16'hFFFF, 17'h1FFFE, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(16'hFFFF, 17'h1FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b1);

    // start_i pulsed mid-operation must be ignored.
    issue(16'h0003, 17'h00007, 1'b1, 32'h0000_0010, 1'b0, 1'b0);
    repeat (4) @(negedge clk_i);
    bus.root_i  = 16'hAAAA;
    bus.rem_i   = 17'h00005;
    bus.start_i = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    wait_done("ignore_done");
    repeat (5) @(negedge clk_i);
    check("hold_radicand", {32'd0, bus.radicand_o}, 64'h10);
    check("hold_valid",    {63'd0, bus.valid_o},    64'd0);
    check("hold_busy",     {63'd0, bus.busy_o},     64'd0);

    // Reset in the middle of an operation.
    issue(16'hABCD, 17'h00000, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (7) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("mid_rst_busy",     {63'd0, bus.busy_o},     64'd0);
    check("mid_rst_done",     {63'd0, bus.done_o},     64'd0);
    check("mid_rst_radicand", {32'd0, bus.radicand_o}, 64'd0);
    check("mid_rst_valid",    {63'd0, bus.valid_o},    64'd0);
    check("mid_rst_ovf",      {63'd0, bus.ovf_o},      64'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk_i);
      if (bus.done_o) seen++;
    end
    check("no_done_after_rst", 64'(seen), 64'd0);
    issue(16'h0002, 17'h00001, 1'b1, 32'h0000_0005, 1'b1, 1'b0);

    // Back-to-back sweep over boundary roots: rem = 0, 2r, 2r+1.
    roots = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h00FF, 16'h0100,
              16'h1234, 16'h7FFF, 16'h8000, 16'hBEEF, 16'hFFFE, 16'hFFFF};
    foreach (roots[i]) begin
      issue_model(roots[i], 17'h00000);
      issue_model(roots[i], {roots[i], 1'b0});
      issue_model(roots[i], {roots[i], 1'b0} + 17'd1);
    end
    for (int k = 0; k < 8; k++) begin
      logic [15:0] r;
      r = 16'($urandom);
      issue_model(r, {r, 1'b0});
      issue_model(r, {r, 1'b0} + 17'd1);
    end

    j = 0;
    while (q.size() != 0 && j < 200) begin
      @(negedge clk_i);
      j++;
    end
    repeat (3) @(negedge clk_i);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
